// File: rtl/wb_dmem_bridge.sv
// Wishbone slave giving the host load/readback access to WARP-V dmem SRAM port 0 while the core is held in reset.
// Optional SRAM readback path is built only when WB_DMEM_BRIDGE_READ_EN is defined.
module wb_dmem_bridge #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_1000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [31:0] wbs_adr_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  input  logic        processor_reset,
  input  logic        core_csb0,
  input  logic        core_web0,
  input  logic [3:0]  core_wmask0,
  input  logic [7:0]  core_addr0,
  input  logic [31:0] core_din0,
  output logic        sram_csb0,
  output logic        sram_web0,
  output logic [3:0]  sram_wmask0,
  output logic [7:0]  sram_addr0,
  output logic [31:0] sram_din0,
  input  logic [31:0] sram_dout0
);

  typedef enum logic [2:0] {
    IDLE,
    WR,
`ifdef WB_DMEM_BRIDGE_READ_EN
    RD,
    RDW,
`endif
    ACK
  } state_t;

  state_t      state, state_n;
  logic [7:0]  adr_q;
  logic [31:0] dat_q;
  logic [3:0]  sel_q;
  logic [15:0] drop_cnt;
  logic        hit, req, own, drop_inc;
  logic [31:0] ack_dat;

  assign hit       = (wbs_adr_i[31:11] == BASE_ADDR[31:11]);
  assign req       = wbs_cyc_i & wbs_stb_i & hit;
  assign wbs_ack_o = (state == ACK);

`ifdef WB_DMEM_BRIDGE_READ_EN
  assign own = processor_reset | (state == WR) | (state == RD);
  logic unused_ok;
  assign unused_ok = ^wbs_adr_i[1:0];
`else
  assign own = processor_reset | (state == WR);
  logic unused_ok;
  assign unused_ok = ^{wbs_adr_i[1:0], sram_dout0};
`endif

  always_comb begin
    state_n  = state;
    ack_dat  = 32'h0;
    drop_inc = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (wbs_adr_i[10]) begin
            state_n = ACK;
            ack_dat = {16'h0, drop_cnt};
          end else if (wbs_we_i) begin
            if (processor_reset) begin
              state_n = WR;
            end else begin
              state_n  = ACK;
              drop_inc = 1'b1;
            end
          end else begin
`ifdef WB_DMEM_BRIDGE_READ_EN
            if (processor_reset) begin
              state_n = RD;
            end else begin
              state_n  = ACK;
              drop_inc = 1'b1;
            end
`else
            // Readback compiled out: reads complete immediately with zero data.
            state_n = ACK;
`endif
          end
        end
      end
      WR:  state_n = ACK;
`ifdef WB_DMEM_BRIDGE_READ_EN
      RD:  state_n = RDW;
      RDW: begin
        state_n = ACK;
        ack_dat = sram_dout0;
      end
`endif
      ACK:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state     <= IDLE;
      adr_q     <= 8'h0;
      dat_q     <= 32'h0;
      sel_q     <= 4'h0;
      drop_cnt  <= 16'h0;
      wbs_dat_o <= 32'h0;
    end else begin
      state     <= state_n;
      wbs_dat_o <= (state_n == ACK) ? ack_dat : 32'h0;
      if (state == IDLE && req) begin
        adr_q <= wbs_adr_i[9:2];
        dat_q <= wbs_dat_i;
        sel_q <= wbs_sel_i;
      end
      if (drop_inc && drop_cnt != 16'hFFFF) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

  // WR/RD keep the port even if processor_reset has just fallen.
  always_comb begin
    sram_csb0   = 1'b1;
    sram_web0   = 1'b1;
    sram_wmask0 = 4'h0;
    sram_addr0  = 8'h0;
    sram_din0   = 32'h0;
    if (own) begin
      if (state == WR) begin
        sram_csb0   = 1'b0;
        sram_web0   = 1'b0;
        sram_wmask0 = sel_q;
        sram_addr0  = adr_q;
        sram_din0   = dat_q;
      end
`ifdef WB_DMEM_BRIDGE_READ_EN
      if (state == RD) begin
        sram_csb0  = 1'b0;
        sram_addr0 = adr_q;
      end
`endif
    end else begin
      sram_csb0   = core_csb0;
      sram_web0   = core_web0;
      sram_wmask0 = core_wmask0;
      sram_addr0  = core_addr0;
      sram_din0   = core_din0;
    end
  end

endmodule
